// File: rtl/systol_pkg.sv
// systol_pkg: shared dimensions, FSM state type and run-step bound for the systolic job sequencer.
package systol_pkg;
  localparam int N = 3;
  localparam int DW = 5;
  localparam int ACCW = 10;
  localparam int RUN_LAST = 3 * N - 2;
  localparam int KW = $clog2(RUN_LAST + 1);
  typedef enum logic [2:0] {IDLE, CLR, RUN, CAPT, DONE} state_t;
endpackage

// File: rtl/systol_skew_feed.sv
// systol_skew_feed: combinational skew mux producing the edge feeds for run step k (all zero when en is low).
module systol_skew_feed
  import systol_pkg::*;
(
  input  logic [N*N*DW-1:0] a_mat,
  input  logic [N*N*DW-1:0] b_mat,
  input  logic [KW-1:0]     k,
  input  logic              en,
  output logic [N*DW-1:0]   left,
  output logic [N*DW-1:0]   top
);
  // Row i (and column i) lags by i steps; indices past N-1 fall out naturally, giving the drain zeros.
  always_comb begin
    left = '0;
    top = '0;
    for (int i = 0; i < N; i++)
      for (int t = 0; t < N; t++)
        if (en && int'(k) - i == t) begin
          left[i*DW +: DW] = a_mat[(i*N+t)*DW +: DW];
          top[i*DW +: DW] = b_mat[(t*N+i)*DW +: DW];
        end
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for the NxN output-stationary systolic MAC array.
// Optional SYSTOL_PERF_EN adds perf_jobs/perf_stall counters.
module systolic_ctrl
  import systol_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 start_rdy,
  input  logic [N*N*DW-1:0]    a_mat,
  input  logic [N*N*DW-1:0]    b_mat,
  output logic                 arr_clr,
  output logic [N*DW-1:0]      arr_left,
  output logic [N*DW-1:0]      arr_top,
  input  logic [N*N*ACCW-1:0]  arr_c,
  output logic [N*N*ACCW-1:0]  res,
  output logic                 res_vld,
  input  logic                 res_rdy
`ifdef SYSTOL_PERF_EN
  ,
  output logic [15:0]          perf_jobs,
  output logic [15:0]          perf_stall
`endif
);
  state_t state;
  logic [KW-1:0] k, k_nxt;
  logic [N*N*DW-1:0] a_q, b_q;
  logic feed_en;
  logic [N*DW-1:0] left_nxt, top_nxt;
  // Feeds are registered, so compute the step that will be visible next cycle.
  assign feed_en = state == CLR || (state == RUN && k != KW'(RUN_LAST));
  assign k_nxt = state == CLR ? '0 : k + KW'(1);
  systol_skew_feed u_feed (
    .a_mat(a_q),
    .b_mat(b_q),
    .k(k_nxt),
    .en(feed_en),
    .left(left_nxt),
    .top(top_nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      start_rdy <= 1'b1;
      arr_clr <= 1'b1;
      arr_left <= '0;
      arr_top <= '0;
      res <= '0;
      res_vld <= 1'b0;
      k <= '0;
      a_q <= '0;
      b_q <= '0;
`ifdef SYSTOL_PERF_EN
      perf_jobs <= '0;
      perf_stall <= '0;
`endif
    end else begin
      arr_left <= left_nxt;
      arr_top <= top_nxt;
      case (state)
        IDLE: if (start) begin
          a_q <= a_mat;
          b_q <= b_mat;
          start_rdy <= 1'b0;
          state <= CLR;
        end
        CLR: begin
          k <= '0;
          arr_clr <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          k <= k_nxt;
          state <= k == KW'(RUN_LAST) ? CAPT : RUN;
        end
        CAPT: begin
          res <= arr_c;
          res_vld <= 1'b1;
          state <= DONE;
        end
        DONE: if (res_rdy) begin
          res_vld <= 1'b0;
          start_rdy <= 1'b1;
          arr_clr <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef SYSTOL_PERF_EN
      if (state == DONE) begin
        perf_jobs <= res_rdy ? perf_jobs + 16'd1 : perf_jobs;
        perf_stall <= res_rdy ? perf_stall : perf_stall + 16'd1;
      end
`endif
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench driving systolic_ctrl against a behavioural output-stationary array.
module tb_systolic_ctrl;
  import systol_pkg::*;
  localparam int AW = N * N * DW;
  localparam int CW = N * N * ACCW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_rdy;
  logic [AW-1:0] a_mat = '0, b_mat = '0;
  logic arr_clr;
  logic [N*DW-1:0] arr_left, arr_top;
  logic [CW-1:0] arr_c, res;
  logic res_vld;
  logic res_rdy = 1'b1;
`ifdef SYSTOL_PERF_EN
  logic [15:0] perf_jobs, perf_stall;
`endif

  systolic_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .start_rdy(start_rdy),
    .a_mat(a_mat), .b_mat(b_mat), .arr_clr(arr_clr),
    .arr_left(arr_left), .arr_top(arr_top), .arr_c(arr_c),
    .res(res), .res_vld(res_vld), .res_rdy(res_rdy)
`ifdef SYSTOL_PERF_EN
    , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  logic [ACCW-1:0] acc [N][N];

  function automatic logic [DW-1:0] ain(input int i, input int j);
    if (j == 0) return arr_left[i*DW +: DW];
    return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] bin(input int i, input int j);
    if (i == 0) return arr_top[j*DW +: DW];
    return pb[i-1][j];
  endfunction

  always @(posedge clk or posedge arr_clr)
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (arr_clr) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j] <= ain(i, j);
          pb[i][j] <= bin(i, j);
          acc[i][j] <= acc[i][j] + ACCW'(int'(ain(i, j)) * int'(bin(i, j)));
        end

  always_comb begin
    arr_c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        arr_c[(i*N+j)*ACCW +: ACCW] = acc[i][j];
  end

  function automatic logic [CW-1:0] matmul(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int t = 0; t < N; t++)
          s += int'(a[(i*N+t)*DW +: DW]) * int'(b[(t*N+j)*DW +: DW]);
        r[(i*N+j)*ACCW +: ACCW] = ACCW'(s);
      end
    return r;
  endfunction

  function automatic logic [AW-1:0] ident();
    logic [AW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = DW'(1);
    return m;
  endfunction

  function automatic logic [CW-1:0] ident_c();
    logic [CW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*ACCW +: ACCW] = ACCW'(1);
    return m;
  endfunction

  logic [CW-1:0] exp_q [$];
  int cyc = 0;
  int acc_cyc = 0;
  int d;
  logic busy = 1'b0;
  logic vld_prev = 1'b0;
  logic [AW-1:0] cur_a, cur_b;
  logic [DW-1:0] el, et;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: feed/clear checks per step, latency, and scoreboard push/pop at the handshakes.
  always @(negedge clk)
    if (rst) begin
      exp_q.delete();
      busy = 1'b0;
      vld_prev = 1'b0;
    end else begin
      if (busy) begin
        d = cyc - acc_cyc;
        if (d <= 9) begin
          check("arr_clr", arr_clr, d == 0);
          for (int i = 0; i < N; i++) begin
            el = '0;
            et = '0;
            if (d >= 1 && d <= 8 && d - 1 - i >= 0 && d - 1 - i < N) begin
              el = cur_a[(i*N+d-1-i)*DW +: DW];
              et = cur_b[((d-1-i)*N+i)*DW +: DW];
            end
            check($sformatf("left%0d_d%0d", i, d), arr_left[i*DW +: DW], el);
            check($sformatf("top%0d_d%0d", i, d), arr_top[i*DW +: DW], et);
          end
        end
      end
      if (res_vld && !vld_prev && busy) check("latency", cyc - acc_cyc, 10);
      vld_prev = res_vld;
      if (res_vld && res_rdy) begin
        check("res_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("res", res, exp_q.pop_front());
        busy = 1'b0;
      end
      if (start && start_rdy) begin
        exp_q.push_back(matmul(a_mat, b_mat));
        acc_cyc = cyc + 1;
        cur_a = a_mat;
        cur_b = b_mat;
        busy = 1'b1;
      end
    end

  task automatic accept(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int t;
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    t = 0;
    while (!start_rdy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("start_rdy_wait", start_rdy, 1);
    @(posedge clk); #1;
    start = 1'b0;
    a_mat = AW'({$urandom, $urandom});
    b_mat = AW'({$urandom, $urandom});
  endtask

  task automatic run_job(input logic [AW-1:0] a, input logic [AW-1:0] b, input int stall);
    int t;
    res_rdy = stall == 0;
    accept(a, b);
    t = 0;
    while (!res_vld && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("res_vld_wait", res_vld, 1);
    for (int s = 0; s < stall; s++) begin
      start = 1'b1;
      check("busy_rdy", start_rdy, 0);
      check("hold_vld", res_vld, 1);
      if (exp_q.size() != 0) check("hold_res", res, exp_q[0]);
      @(posedge clk); #1;
    end
    start = 1'b0;
    res_rdy = 1'b1;
    @(posedge clk); #1;
    check("post_vld", res_vld, 0);
    check("post_rdy", start_rdy, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_start_rdy", start_rdy, 1);
    check("rst_arr_clr", arr_clr, 1);
    check("rst_left", arr_left, 0);
    check("rst_top", arr_top, 0);
    check("rst_res", res, 0);
    check("rst_res_vld", res_vld, 0);
  endtask

  logic [AW-1:0] a1, a31;

  initial begin
    a1 = '0;
    a31 = '0;
    for (int i = 0; i < N * N; i++) begin
      a1[i*DW +: DW] = DW'(i + 1);
      a31[i*DW +: DW] = DW'(31);
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(a1, ident(), 0);
    run_job(a31, a31, 0);
    check("all31_model", matmul(a31, a31), {(N*N){ACCW'(835)}});
    run_job(ident(), a1, 5);
    // Abort a job at RUN step 3 and confirm the asynchronous return to reset values.
    res_rdy = 1'b1;
    accept(a31, a1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    run_job(ident(), ident(), 0);
    check("ident_model", matmul(ident(), ident()), ident_c());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_job(a1, a31, 0);
    run_job(a31, ident(), 1);
    run_job(AW'({$urandom, $urandom}), AW'({$urandom, $urandom}), 3);
`ifdef SYSTOL_PERF_EN
    check("perf_jobs", perf_jobs, 3);
    check("perf_stall", perf_stall, 4);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
